register_bank: RTL and testbench

Parametrised general-purpose register bank for the 32-bit datapath, the next generation after the single-word and two-word registers. It holds DEPTH words of WIDTH bits and provides one byte-maskable write port, an increment port for counter and program-counter use, two always-driven read ports for the ALU, and one tri-state bus port for the shared bus. It sits between the control unit, the ALU operand muxes and the internal bus.

---
 rtl/register_bank.sv | 95 +++++++++
 tb/tb_register_bank.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// General-purpose register bank with a byte-masked write port, an increment port, two
// combinational read ports and a tri-state bus port. All state changes on the falling clock edge.
module register_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               inc_en,
    input  logic [AW-1:0]      inc_addr,
    output logic               inc_carry,
    input  logic [AW-1:0]      rd_a_addr,
    input  logic [AW-1:0]      rd_b_addr,
    output logic [WIDTH-1:0]   rd_a_data,
    output logic [WIDTH-1:0]   rd_b_data,
    input  logic               bus_oe,
    input  logic [AW-1:0]      bus_addr,
    output logic [WIDTH-1:0]   bus_out
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs      [DEPTH];
    logic [WIDTH-1:0] regs_next [DEPTH];
    logic             carry_next;
    logic             wr_ok;
    logic             inc_ok;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] bus_word;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] base,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] result;
        result = base;
        for (int b = 0; b < NB; b++)
            if (be[b]) result[8*b +: 8] = data[8*b +: 8];
        return result;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    assign wr_ok   = wr_en  && !is_zero_reg(wr_addr);
    assign inc_ok  = inc_en && !is_zero_reg(inc_addr);
    assign inc_sum = {1'b0, regs[inc_addr]} + {{WIDTH{1'b0}}, 1'b1};

    // Increment first, then overlay the enabled write bytes so a same-address write wins.
    always_comb begin
        carry_next = inc_carry;
        for (int i = 0; i < DEPTH; i++) begin
            regs_next[i] = regs[i];
            if (inc_ok && inc_addr == AW'(i))
                regs_next[i] = inc_sum[WIDTH-1:0];
            if (wr_ok && wr_addr == AW'(i))
                regs_next[i] = merge_bytes(regs_next[i], wr_data, wr_be);
        end
        if (inc_ok)
            carry_next = inc_sum[WIDTH];
    end

    // NOTE: the storage array is reset as a whole, since every address must read 0 as soon as reset asserts.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            inc_carry <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= regs_next[i];
            inc_carry <= carry_next;
        end
    end

    always_comb begin
        rd_a_data = is_zero_reg(rd_a_addr) ? '0 : regs[rd_a_addr];
        rd_b_data = is_zero_reg(rd_b_addr) ? '0 : regs[rd_b_addr];
        bus_word  = is_zero_reg(bus_addr)  ? '0 : regs[bus_addr];
        // wr_ok already excludes the zero register, so bypass never exposes it.
        if (BYPASS && wr_ok && rd_a_addr == wr_addr)
            rd_a_data = merge_bytes(regs[rd_a_addr], wr_data, wr_be);
        if (BYPASS && wr_ok && rd_b_addr == wr_addr)
            rd_b_data = merge_bytes(regs[rd_b_addr], wr_data, wr_be);
    end

    assign bus_out = bus_oe ? bus_word : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a bypassing instance and a non-bypassing
// instance share all inputs so forwarding and plain-storage behaviour are both observed.
module tb_register_bank;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NB    = 4;

    logic             clk = 1'b1;
    logic             reset;
    logic             wr_en, inc_en, bus_oe;
    logic [AW-1:0]    wr_addr, inc_addr, rd_a_addr, rd_b_addr, bus_addr;
    logic [NB-1:0]    wr_be;
    logic [WIDTH-1:0] wr_data;
    logic             inc_carry, nb_inc_carry;
    logic [WIDTH-1:0] rd_a_data, rd_b_data, nb_rd_a_data, nb_rd_b_data;
    logic [WIDTH-1:0] bus_out, nb_bus_out;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_val;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .inc_en(inc_en), .inc_addr(inc_addr), .inc_carry(inc_carry),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data),
        .rd_b_data(rd_b_data), .bus_oe(bus_oe), .bus_addr(bus_addr), .bus_out(bus_out)
    );

    register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .inc_en(inc_en), .inc_addr(inc_addr), .inc_carry(nb_inc_carry),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(nb_rd_a_data),
        .rd_b_data(nb_rd_b_data), .bus_oe(bus_oe), .bus_addr(bus_addr), .bus_out(nb_bus_out)
    );

    // Inputs change 1 time unit after a falling edge, so they are stable at the next one.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_inc(input logic [AW-1:0] a);
        inc_en = 1'b1; inc_addr = a;
        tick();
        inc_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int i = 0; i < DEPTH; i++) sb.push_back('0);
        sb.push_back('0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_a_addr = AW'(i);
            #1;
            exp_val = sb.pop_front(); checks++;
            if (rd_a_data !== exp_val) begin
                failures++; $display("FAIL reset_rd_a[%0d] got=%h exp=%h", i, rd_a_data, exp_val);
            end
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL reset_carry got=%b exp=%h", inc_carry, exp_val);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_write(3, 32'hDEADBEEF, 4'hF);
        sb.push_back(32'hDEADBEEF);
        rd_a_addr = 3; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL mid_write_r3 got=%h exp=%h", rd_a_data, exp_val);
        end
        do_write(5, 32'hFFFFFFFF, 4'hF);
        do_inc(5);
        sb.push_back(32'h1);
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL mid_carry_set got=%b exp=%h", inc_carry, exp_val);
        end
        #1;
        reset = 1'b0;
        sb.push_back('0); sb.push_back('0);
        #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL mid_reset_r3 got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL mid_reset_carry got=%b exp=%h", inc_carry, exp_val);
        end
        #1;
        reset = 1'b1;
        tick(); tick();
        sb.push_back('0); sb.push_back('0);
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL post_reset_r3 got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL post_reset_carry got=%b exp=%h", inc_carry, exp_val);
        end
    endtask

    task automatic test_byte_enable();
        do_write(2, 32'h11223344, 4'hF);
        do_write(2, 32'hAABBCCDD, 4'b0101);
        sb.push_back(32'h11BB33DD); sb.push_back(32'h11BB33DD);
        rd_a_addr = 2; rd_b_addr = 2; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL be_0101 got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (nb_rd_b_data !== exp_val) begin
            failures++; $display("FAIL be_0101_nb got=%h exp=%h", nb_rd_b_data, exp_val);
        end
        do_write(2, 32'hFFFFFFFF, 4'b0000);
        sb.push_back(32'h11BB33DD);
        exp_val = sb.pop_front(); checks++;
        if (rd_b_data !== exp_val) begin
            failures++; $display("FAIL be_none got=%h exp=%h", rd_b_data, exp_val);
        end
        do_write(2, 32'hA5A5A5A5, 4'b1010);
        sb.push_back(32'hA5BBA5DD);
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL be_1010 got=%h exp=%h", rd_a_data, exp_val);
        end
    endtask

    task automatic test_inc_wrap();
        do_write(5, 32'hFFFFFFFF, 4'hF);
        do_inc(5);
        sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h1);
        rd_a_addr = 5; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL wrap_value got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL wrap_carry got=%b exp=%h", inc_carry, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, nb_inc_carry} !== exp_val) begin
            failures++; $display("FAIL wrap_carry_nb got=%b exp=%h", nb_inc_carry, exp_val);
        end
        tick();
        sb.push_back(32'h1);
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL carry_hold got=%b exp=%h", inc_carry, exp_val);
        end
        do_inc(5);
        sb.push_back(32'h1); sb.push_back(32'h0);
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL inc_after_wrap got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL carry_clear got=%b exp=%h", inc_carry, exp_val);
        end
    endtask

    task automatic test_collision();
        do_write(4, 32'h000000FF, 4'hF);
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h12345678; wr_be = 4'b0001;
        inc_en = 1'b1; inc_addr = 4;
        tick();
        wr_en = 1'b0; inc_en = 1'b0;
        sb.push_back(32'h00000178);
        rd_a_addr = 4; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL collide_same got=%h exp=%h", rd_a_data, exp_val);
        end
        do_write(4, 32'hFFFFFFFF, 4'hF);
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h12345678; wr_be = 4'b0001;
        inc_en = 1'b1; inc_addr = 4;
        tick();
        wr_en = 1'b0; inc_en = 1'b0;
        sb.push_back(32'h00000078); sb.push_back(32'h1);
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL collide_wrap got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL collide_carry got=%b exp=%h", inc_carry, exp_val);
        end
        wr_en = 1'b1; wr_addr = 6; wr_data = 32'h0000ABCD; wr_be = 4'hF;
        inc_en = 1'b1; inc_addr = 7;
        tick();
        wr_en = 1'b0; inc_en = 1'b0;
        sb.push_back(32'h0000ABCD); sb.push_back(32'h1);
        rd_a_addr = 6; rd_b_addr = 7; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL diff_addr_write got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (rd_b_data !== exp_val) begin
            failures++; $display("FAIL diff_addr_inc got=%h exp=%h", rd_b_data, exp_val);
        end
    endtask

    task automatic test_zero_bypass();
        do_write(0, 32'h00000055, 4'hF);
        sb.push_back('0); sb.push_back('0); sb.push_back('0);
        rd_a_addr = 0; rd_b_addr = 0; bus_addr = 0; bus_oe = 1'b1; #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL zero_rd_a got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (rd_b_data !== exp_val) begin
            failures++; $display("FAIL zero_rd_b got=%h exp=%h", rd_b_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL zero_bus got=%h exp=%h", bus_out, exp_val);
        end
        bus_oe = 1'b0;
        do_write(5, 32'hFFFFFFFF, 4'hF);
        do_inc(5);
        do_inc(0);
        sb.push_back('0); sb.push_back(32'h1);
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL zero_inc_value got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if ({31'b0, inc_carry} !== exp_val) begin
            failures++; $display("FAIL zero_inc_carry got=%b exp=%h", inc_carry, exp_val);
        end
        do_write(1, 32'h11111111, 4'hF);
        wr_en = 1'b1; wr_addr = 1; wr_data = 32'hCAFE0000; wr_be = 4'hF;
        rd_a_addr = 1; bus_addr = 1; bus_oe = 1'b1;
        sb.push_back(32'hCAFE0000); sb.push_back(32'h11111111); sb.push_back(32'h11111111);
        #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL bypass_rd_a got=%h exp=%h", rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (nb_rd_a_data !== exp_val) begin
            failures++; $display("FAIL no_bypass_rd_a got=%h exp=%h", nb_rd_a_data, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL bus_no_bypass got=%h exp=%h", bus_out, exp_val);
        end
        tick();
        wr_en = 1'b0;
        sb.push_back(32'hCAFE0000);
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL bus_after_edge got=%h exp=%h", bus_out, exp_val);
        end
        bus_oe = 1'b0;
        wr_en = 1'b1; wr_addr = 1; wr_data = 32'h12345678; wr_be = 4'b0011; rd_b_addr = 1;
        sb.push_back(32'hCAFE5678);
        #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_b_data !== exp_val) begin
            failures++; $display("FAIL bypass_partial got=%h exp=%h", rd_b_data, exp_val);
        end
        tick();
        wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF; rd_a_addr = 0;
        sb.push_back('0);
        #1;
        exp_val = sb.pop_front(); checks++;
        if (rd_a_data !== exp_val) begin
            failures++; $display("FAIL bypass_zero_reg got=%h exp=%h", rd_a_data, exp_val);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_bus();
        bus_oe = 1'b0; bus_addr = 6;
        sb.push_back({WIDTH{1'bz}});
        #1;
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL bus_hiz got=%h exp=%h", bus_out, exp_val);
        end
        bus_oe = 1'b1;
        sb.push_back(32'h0000ABCD); sb.push_back(32'h0000ABCD);
        #1;
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL bus_drive got=%h exp=%h", bus_out, exp_val);
        end
        exp_val = sb.pop_front(); checks++;
        if (nb_bus_out !== exp_val) begin
            failures++; $display("FAIL bus_drive_nb got=%h exp=%h", nb_bus_out, exp_val);
        end
        bus_oe = 1'b0;
        sb.push_back({WIDTH{1'bz}});
        #1;
        exp_val = sb.pop_front(); checks++;
        if (bus_out !== exp_val) begin
            failures++; $display("FAIL bus_release got=%h exp=%h", bus_out, exp_val);
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; inc_en = 1'b0; bus_oe = 1'b0;
        wr_addr = '0; inc_addr = '0; rd_a_addr = '0; rd_b_addr = '0; bus_addr = '0;
        wr_be = '0; wr_data = '0;
        test_reset();
        test_reset_mid();
        test_byte_enable();
        test_inc_wrap();
        test_collision();
        test_zero_bypass();
        test_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

endmodule
